// File: rtl/ppt_pkg.sv
// Shared types and widths for the PPT pulse-train generator.
// Package name is ppt_pkg so both the prescaler and the top share one state type.
package ppt_pkg;
  localparam int CLKDIV_W = 5;
  localparam int TIME_W   = 14;
  localparam int COUNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ppt_state_e;
endpackage

// File: rtl/ppt_prescaler.sv
// Tick generator: one tick every 2^(d+1) clk cycles, d = clk_div clamped to PRESC_W-1.
// The divider is latched on load so it stays constant for the whole run.
module ppt_prescaler
  import ppt_pkg::*;
#(
  parameter int PRESC_W = 24
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                load,
  input  logic                en,
  input  logic [CLKDIV_W-1:0] clk_div,
  output logic                tick
);
  localparam logic [CLKDIV_W-1:0] MAX_D = CLKDIV_W'(PRESC_W - 1);
  localparam logic [PRESC_W-1:0]  ONES  = '1;

  logic [PRESC_W-1:0]  cnt_q;
  logic [PRESC_W-1:0]  term_q;
  logic [CLKDIV_W-1:0] d_clamped;

  always_comb begin
    d_clamped = (clk_div > MAX_D) ? MAX_D : clk_div;
  end

  // Terminal count 2^(d+1)-1 is an all-ones mask of d+1 bits.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      term_q <= '0;
    end else if (load) begin
      cnt_q  <= '0;
      term_q <= ONES >> (MAX_D - d_clamped);
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == term_q);
endmodule

// File: rtl/ppt_pulse_gen.sv
// PPT trigger pulse-train generator: shadowed config, phase counter, firing counter.
// run_ppt is a level: high starts a run from IDLE, low aborts RUN or leaves DONE.
module ppt_pulse_gen
  import ppt_pkg::*;
#(
  parameter int PRESC_W = 24
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CLKDIV_W-1:0] clk_div,
  input  logic [TIME_W-1:0]   period,
  input  logic [TIME_W-1:0]   width,
  input  logic [COUNT_W-1:0]  count,
  input  logic                run_ppt,
  output logic                pulse_out,
  output logic [COUNT_W-1:0]  count_done,
  output logic                done,
  output logic                busy
);
  ppt_state_e         state_q, state_d;
  logic [TIME_W-1:0]  period_q, period_d;
  logic [TIME_W-1:0]  width_q, width_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [TIME_W-1:0]  phase_q, phase_d;
  logic [COUNT_W-1:0] cd_q, cd_d;
  logic               done_q, done_d;
  logic               pulse_q, pulse_d;

  logic               start;
  logic               tick;
  logic [TIME_W-1:0]  eff_period_in;
  logic [TIME_W-1:0]  eff_width_in;
  logic [TIME_W-1:0]  phase_inc;
  logic [COUNT_W-1:0] cd_inc;

  assign start = (state_q == IDLE) && run_ppt;

  ppt_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk     (clk),
    .rstn    (rstn),
    .load    (start),
    .en      (state_q == RUN),
    .clk_div (clk_div),
    .tick    (tick)
  );

  always_comb begin
    eff_period_in = (period == '0) ? TIME_W'(1) : period;
    eff_width_in  = (width > eff_period_in) ? eff_period_in : width;
    phase_inc     = phase_q + TIME_W'(1);
    cd_inc        = cd_q + COUNT_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    width_d  = width_q;
    count_d  = count_q;
    phase_d  = phase_q;
    cd_d     = cd_q;
    done_d   = done_q;
    pulse_d  = pulse_q;
    case (state_q)
      IDLE: begin
        pulse_d = 1'b0;
        if (run_ppt) begin
          period_d = eff_period_in;
          width_d  = eff_width_in;
          count_d  = count;
          phase_d  = '0;
          cd_d     = '0;
          if (count == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
            done_d  = 1'b0;
            pulse_d = (eff_width_in != '0);
          end
        end
      end
      RUN: begin
        // Abort wins over a coincident completing tick.
        if (!run_ppt) begin
          state_d = IDLE;
          pulse_d = 1'b0;
        end else if (tick) begin
          if (phase_q == period_q - TIME_W'(1)) begin
            phase_d = '0;
            cd_d    = cd_inc;
            if (cd_inc == count_q) begin
              state_d = DONE;
              done_d  = 1'b1;
              pulse_d = 1'b0;
            end else begin
              pulse_d = (width_q != '0);
            end
          end else begin
            phase_d = phase_inc;
            pulse_d = (phase_inc < width_q);
          end
        end
      end
      DONE: begin
        pulse_d = 1'b0;
        if (!run_ppt) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      period_q <= '0;
      width_q  <= '0;
      count_q  <= '0;
      phase_q  <= '0;
      cd_q     <= '0;
      done_q   <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      width_q  <= width_d;
      count_q  <= count_d;
      phase_q  <= phase_d;
      cd_q     <= cd_d;
      done_q   <= done_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_out  = pulse_q;
  assign count_done = cd_q;
  assign done       = done_q;
  assign busy       = (state_q == RUN);
endmodule

// File: tb/tb_ppt_pulse_gen.sv
// Directed bench for ppt_pulse_gen: hand-computed pulse timing, abort, reset and clamp cases.
module tb_ppt_pulse_gen;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [4:0]  clk_div = 5'd0;
  logic [13:0] period = 14'd0;
  logic [13:0] width = 14'd0;
  logic [7:0]  count = 8'd0;
  logic        run_ppt = 1'b0;
  logic        pulse_out;
  logic [7:0]  count_done;
  logic        done;
  logic        busy;

  logic        run_s = 1'b0;
  logic        pulse_s;
  logic [7:0]  cd_s;
  logic        done_s;
  logic        busy_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ppt_pulse_gen #(.PRESC_W(24)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div    (clk_div),
    .period     (period),
    .width      (width),
    .count      (count),
    .run_ppt    (run_ppt),
    .pulse_out  (pulse_out),
    .count_done (count_done),
    .done       (done),
    .busy       (busy)
  );

  // Narrow prescaler instance: clk_div=31 clamps to 3, tick every 16 cycles.
  ppt_pulse_gen #(.PRESC_W(4)) u_dut_small (
    .clk        (clk),
    .rstn       (rstn),
    .clk_div    (clk_div),
    .period     (period),
    .width      (width),
    .count      (count),
    .run_ppt    (run_s),
    .pulse_out  (pulse_s),
    .count_done (cd_s),
    .done       (done_s),
    .busy       (busy_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [4:0] d, input logic [13:0] p, input logic [13:0] w,
                     input logic [7:0] c);
    clk_div = d;
    period  = p;
    width   = w;
    count   = c;
  endtask

  initial begin
    #2;
    check("rst_pulse", 32'(pulse_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cd", 32'(count_done), 0);
    #21 rstn = 1'b1;
    step();

    // Basic run: d=0, period 4, width 1, count 3 -> 2-cycle pulses every 8 cycles.
    cfg(5'd0, 14'd4, 14'd1, 8'd3);
    run_ppt = 1'b1;
    step();
    for (int k = 0; k < 24; k++) begin
      check("t1_pulse", 32'(pulse_out), 32'((k % 8) < 2));
      check("t1_busy", 32'(busy), 1);
      check("t1_cd", 32'(count_done), 32'(k / 8));
      check("t1_done", 32'(done), 0);
      if (k == 3) cfg(5'd2, 14'd9, 14'd5, 8'd7);
      step();
    end
    check("t1_end_done", 32'(done), 1);
    check("t1_end_cd", 32'(count_done), 3);
    check("t1_end_busy", 32'(busy), 0);
    check("t1_end_pulse", 32'(pulse_out), 0);
    for (int k = 0; k < 20; k++) begin
      step();
      check("t1_hold_pulse", 32'(pulse_out), 0);
      check("t1_hold_done", 32'(done), 1);
      check("t1_hold_busy", 32'(busy), 0);
    end

    // Restart with new values: d=1, period 2, width 1, count 2.
    run_ppt = 1'b0;
    step();
    check("rs_idle_done", 32'(done), 1);
    check("rs_idle_cd", 32'(count_done), 3);
    cfg(5'd1, 14'd2, 14'd1, 8'd2);
    run_ppt = 1'b1;
    step();
    check("rs_done_clr", 32'(done), 0);
    for (int k = 0; k < 16; k++) begin
      check("rs_pulse", 32'(pulse_out), 32'((k % 8) < 4));
      check("rs_cd", 32'(count_done), 32'(k / 8));
      step();
    end
    check("rs_end_done", 32'(done), 1);
    check("rs_end_cd", 32'(count_done), 2);

    // count = 0 goes straight to DONE.
    run_ppt = 1'b0;
    step();
    cfg(5'd0, 14'd4, 14'd2, 8'd0);
    run_ppt = 1'b1;
    step();
    check("c0_done", 32'(done), 1);
    check("c0_cd", 32'(count_done), 0);
    check("c0_busy", 32'(busy), 0);
    for (int k = 0; k < 6; k++) begin
      check("c0_pulse", 32'(pulse_out), 0);
      step();
    end

    // width 0 with period 3: pulse never rises, two firings of 6 cycles.
    run_ppt = 1'b0;
    step();
    cfg(5'd0, 14'd3, 14'd0, 8'd2);
    run_ppt = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      check("w0_pulse", 32'(pulse_out), 0);
      check("w0_busy", 32'(busy), 1);
      step();
    end
    check("w0_done", 32'(done), 1);
    check("w0_cd", 32'(count_done), 2);

    // width 7 clamps to period 3: pulse high for the whole run.
    run_ppt = 1'b0;
    step();
    cfg(5'd0, 14'd3, 14'd7, 8'd2);
    run_ppt = 1'b1;
    step();
    for (int k = 0; k < 12; k++) begin
      check("wf_pulse", 32'(pulse_out), 1);
      step();
    end
    check("wf_end_pulse", 32'(pulse_out), 0);
    check("wf_done", 32'(done), 1);
    check("wf_cd", 32'(count_done), 2);

    // Abort during the third pulse.
    run_ppt = 1'b0;
    step();
    cfg(5'd0, 14'd4, 14'd2, 8'd5);
    run_ppt = 1'b1;
    step();
    for (int k = 0; k < 17; k++) step();
    check("ab_pulse_pre", 32'(pulse_out), 1);
    run_ppt = 1'b0;
    step();
    check("ab_pulse", 32'(pulse_out), 0);
    check("ab_busy", 32'(busy), 0);
    check("ab_done", 32'(done), 0);
    check("ab_cd", 32'(count_done), 2);
    step();
    check("ab_cd_hold", 32'(count_done), 2);

    // Abort coinciding with the final tick: no increment, no done.
    cfg(5'd0, 14'd2, 14'd1, 8'd1);
    run_ppt = 1'b1;
    step();
    for (int k = 0; k < 3; k++) step();
    check("abf_busy_pre", 32'(busy), 1);
    run_ppt = 1'b0;
    step();
    check("abf_cd", 32'(count_done), 0);
    check("abf_done", 32'(done), 0);
    check("abf_busy", 32'(busy), 0);

    // Asynchronous reset mid-pulse after one firing.
    cfg(5'd0, 14'd4, 14'd2, 8'd3);
    run_ppt = 1'b1;
    step();
    for (int k = 0; k < 9; k++) step();
    check("rm_pulse_pre", 32'(pulse_out), 1);
    check("rm_cd_pre", 32'(count_done), 1);
    #2 rstn = 1'b0;
    #1;
    check("rm_pulse", 32'(pulse_out), 0);
    check("rm_busy", 32'(busy), 0);
    check("rm_done", 32'(done), 0);
    check("rm_cd", 32'(count_done), 0);
    run_ppt = 1'b0;
    step();
    rstn = 1'b1;
    step();
    check("rm_idle_busy", 32'(busy), 0);
    check("rm_idle_pulse", 32'(pulse_out), 0);

    // Clamped divider on the narrow instance: period 2, width 1, tick every 16.
    cfg(5'd31, 14'd2, 14'd1, 8'd1);
    run_s = 1'b1;
    step();
    for (int k = 0; k < 32; k++) begin
      check("cl_pulse", 32'(pulse_s), 32'(k < 16));
      check("cl_busy", 32'(busy_s), 1);
      step();
    end
    check("cl_done", 32'(done_s), 1);
    check("cl_cd", 32'(cd_s), 1);
    check("cl_end_busy", 32'(busy_s), 0);
    run_s = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
